// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding mux selects
// and the memory-freeze FSM state type.
package mips_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register.
// The younger EX/MEM result wins over MEM/WB, and register 0 never forwards.
module fwd_unit
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_src,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_mem_wb_dest,
    input  logic       i_wb_reg_write,
    input  logic [4:0] i_wb_dest,
    output logic [1:0] o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = i_mem_reg_write && (i_mem_wb_dest != 5'd0) && (i_mem_wb_dest == i_ex_src);
    assign w_hit_wb  = i_wb_reg_write && (i_wb_dest != 5'd0) && (i_wb_dest == i_ex_src);

    always_comb begin
        o_sel = FWD_REG;
        if (w_hit_mem) begin
            o_sel = FWD_EXMEM;
        end else if (w_hit_wb) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding scheduler for the 5-stage pipeline: memory freeze FSM,
// branch flush, load-use bubble, operand forwarding and saturating event counters.
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wb_dest,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_wb_dest,
    input  logic             mem_access,
    input  logic             mem_pcsrc,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_dest,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam bit HAS_FREEZE = (MEM_LAT > 1);
    localparam int WCW        = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam int WLOAD_INT  = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [WCW-1:0] WLOAD = WCW'(WLOAD_INT);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_freeze;
    logic       w_load_use;
    logic       w_stall_evt;
    logic       w_flush_evt;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // The first frozen cycle is spent in RUN, so WAIT only needs MEM_LAT-2 more
    // frozen cycles plus one release cycle that ignores mem_access.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_freeze    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (HAS_FREEZE && mem_access) begin
                        w_freeze    = 1'b1;
                        w_wait_nxt  = WLOAD;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        w_freeze   = 1'b1;
                        w_wait_nxt = r_wait_cnt - 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign w_load_use = ex_mem_read && (ex_wb_dest != 5'd0) &&
                        ((ex_wb_dest == id_rs) || (id_uses_rt && (ex_wb_dest == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_write = 1'b1;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (mem_pcsrc) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign busy = w_freeze;

    fwd_unit u_fwd_a (
        .i_ex_src        (ex_rs),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_wb_dest   (mem_wb_dest),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_dest       (wb_dest),
        .o_sel           (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_ex_src        (ex_rt),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_wb_dest   (mem_wb_dest),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_dest       (wb_dest),
        .o_sel           (w_fwd_b)
    );

    assign fwd_a = rst ? FWD_REG : w_fwd_a;
    assign fwd_b = rst ? FWD_REG : w_fwd_b;

    assign w_stall_evt = !rst && (w_freeze || (!mem_pcsrc && w_load_use));
    assign w_flush_evt = !rst && !w_freeze && mem_pcsrc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench: two controllers (MEM_LAT=3 and MEM_LAT=1, narrow
// counters) driven in parallel and compared each cycle against a cycle-level model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wb_dest, mem_wb_dest, wb_dest;
    logic       id_uses_rt, ex_mem_read, mem_reg_write, mem_access, mem_pcsrc, wb_reg_write;

    logic       pc_write0, if_id_write0, if_id_flush0, id_ex_write0, id_ex_bubble0;
    logic       ex_mem_write0, ex_mem_flush0, mem_wb_write0, busy0;
    logic [1:0] fwd_a0, fwd_b0;
    logic [4:0] stall0, flush0;

    logic       pc_write1, if_id_write1, if_id_flush1, id_ex_write1, id_ex_bubble1;
    logic       ex_mem_write1, ex_mem_flush1, mem_wb_write1, busy1;
    logic [1:0] fwd_a1, fwd_b1;
    logic [5:0] stall1, flush1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int     lat      [2] = '{3, 1};
    longint cnt_max  [2] = '{31, 63};
    int     m_left   [2];
    longint m_stall  [2];
    longint m_flush  [2];

    logic [8:0]  act_ctrl  [2];
    logic [3:0]  act_fwd   [2];
    logic [63:0] act_stall [2];
    logic [63:0] act_flush [2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(5)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_wb_dest(ex_wb_dest),
        .mem_reg_write(mem_reg_write), .mem_wb_dest(mem_wb_dest), .mem_access(mem_access),
        .mem_pcsrc(mem_pcsrc), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
        .id_ex_write(id_ex_write0), .id_ex_bubble(id_ex_bubble0), .ex_mem_write(ex_mem_write0),
        .ex_mem_flush(ex_mem_flush0), .mem_wb_write(mem_wb_write0), .fwd_a(fwd_a0),
        .fwd_b(fwd_b0), .busy(busy0), .stall_cycles(stall0), .flush_events(flush0)
    );

    pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_wb_dest(ex_wb_dest),
        .mem_reg_write(mem_reg_write), .mem_wb_dest(mem_wb_dest), .mem_access(mem_access),
        .mem_pcsrc(mem_pcsrc), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
        .id_ex_write(id_ex_write1), .id_ex_bubble(id_ex_bubble1), .ex_mem_write(ex_mem_write1),
        .ex_mem_flush(ex_mem_flush1), .mem_wb_write(mem_wb_write1), .fwd_a(fwd_a1),
        .fwd_b(fwd_b1), .busy(busy1), .stall_cycles(stall1), .flush_events(flush1)
    );

    assign act_ctrl[0] = {pc_write0, if_id_write0, if_id_flush0, id_ex_write0, id_ex_bubble0,
                          ex_mem_write0, ex_mem_flush0, mem_wb_write0, busy0};
    assign act_ctrl[1] = {pc_write1, if_id_write1, if_id_flush1, id_ex_write1, id_ex_bubble1,
                          ex_mem_write1, ex_mem_flush1, mem_wb_write1, busy1};
    assign act_fwd[0]   = {fwd_a0, fwd_b0};
    assign act_fwd[1]   = {fwd_a1, fwd_b1};
    assign act_stall[0] = 64'(stall0);
    assign act_stall[1] = 64'(stall1);
    assign act_flush[0] = 64'(flush0);
    assign act_flush[1] = 64'(flush1);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (rst) return 2'b00;
        if (mem_reg_write && mem_wb_dest != 0 && mem_wb_dest == src) return 2'b10;
        if (wb_reg_write && wb_dest != 0 && wb_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    // Order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, ex_mem_flush, mem_wb_w, busy
    function automatic logic [8:0] ctrl_ref(input bit frz, input bit lu);
        if (rst)       return 9'b0_0_1_0_1_0_1_0_0;
        if (frz)       return 9'b0_0_0_0_0_0_0_0_1;
        if (mem_pcsrc) return 9'b1_1_1_1_1_1_1_1_0;
        if (lu)        return 9'b0_0_0_1_1_1_0_1_0;
        return 9'b1_1_0_1_0_1_0_1_0;
    endfunction

    // Inputs are stable #1 after a rising edge; outputs are checked at the falling edge,
    // then the model advances to mirror the next rising edge.
    task automatic run_cycle();
        bit frz, lu;
        #4;
        lu = ex_mem_read && ex_wb_dest != 0 &&
             (ex_wb_dest == id_rs || (id_uses_rt && ex_wb_dest == id_rt));
        for (int k = 0; k < 2; k++) begin
            frz = 1'b0;
            if (!rst) begin
                if (m_left[k] > 0) frz = (m_left[k] > 1);
                else               frz = mem_access && (lat[k] > 1);
            end
            check_val($sformatf("ctrl%0d", k), 64'(act_ctrl[k]), 64'(ctrl_ref(frz, lu)));
            check_val($sformatf("fwd%0d", k), 64'(act_fwd[k]), 64'({fwd_ref(ex_rs), fwd_ref(ex_rt)}));
            check_val($sformatf("stall%0d", k), act_stall[k], 64'(m_stall[k]));
            check_val($sformatf("flush%0d", k), act_flush[k], 64'(m_flush[k]));
            if (rst) begin
                m_left[k]  = 0;
                m_stall[k] = 0;
                m_flush[k] = 0;
            end else begin
                if (m_left[k] > 0) m_left[k]--;
                else if (frz)      m_left[k] = lat[k] - 1;
                if ((frz || (!mem_pcsrc && lu)) && m_stall[k] < cnt_max[k]) m_stall[k]++;
                if (!frz && mem_pcsrc && m_flush[k] < cnt_max[k]) m_flush[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_rs = 5'd3; ex_rt = 5'd4; ex_mem_read = 1'b0; ex_wb_dest = 5'd0;
        mem_reg_write = 1'b0; mem_wb_dest = 5'd0; mem_access = 1'b0; mem_pcsrc = 1'b0;
        wb_reg_write = 1'b0; wb_dest = 5'd0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();

        ex_mem_read = 1'b1; ex_wb_dest = 5'd5; id_rs = 5'd5;
        run_cycle();
        idle_inputs();
        run_cycle();

        mem_access = 1'b1;
        run_cycle();
        mem_access = 1'b0;
        repeat (3) run_cycle();

        mem_pcsrc = 1'b1; ex_mem_read = 1'b1; ex_wb_dest = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1;
        run_cycle();
        idle_inputs();

        mem_reg_write = 1'b1; wb_reg_write = 1'b1; mem_wb_dest = 5'd7; wb_dest = 5'd7;
        ex_rs = 5'd7; ex_rt = 5'd7;
        run_cycle();
        ex_rs = 5'd0; mem_wb_dest = 5'd0; wb_dest = 5'd0;
        run_cycle();
        idle_inputs();

        mem_access = 1'b1;
        run_cycle();
        mem_access = 1'b0; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        repeat (2) run_cycle();

        for (int i = 0; i < 3000; i++) begin
            rst           = (i < 1500) && ($urandom_range(0, 99) < 2);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_rs         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            ex_mem_read   = ($urandom_range(0, 9) < 4);
            ex_wb_dest    = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_wb_dest   = 5'($urandom_range(0, 3));
            mem_access    = ($urandom_range(0, 3) == 0);
            mem_pcsrc     = ($urandom_range(0, 19) < 3);
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_dest       = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) id_rs = 5'($urandom_range(0, 31));
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
